// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing a single-port memory between instruction fetch (IF) and load/store (LS).
// One transaction in flight: IDLE -> ISSUE -> WAIT -> RESP, with a fixed memory latency.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int RR_EN       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic              ls_write,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_LS = 1'b1;
  localparam logic RR       = (RR_EN != 0);
  localparam logic [3:0] WAIT_LOAD = 4'(MEM_LATENCY - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] count;
  logic       last_grant;
  logic       owner;
  logic       write_lat;
  logic       pick_if;
  logic       pick_ls;
  logic       accept;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // LS wins a tie unless round-robin says IF is due (LS was granted last).
  always_comb begin
    state_next   = state;
    pick_if      = 1'b0;
    pick_ls      = 1'b0;
    accept       = 1'b0;
    if_req_ready = 1'b0;
    ls_req_ready = 1'b0;
    case (state)
      IDLE: begin
        pick_ls      = ls_req_valid &
                       (~if_req_valid | ~RR | (last_grant == GRANT_IF));
        pick_if      = if_req_valid & ~pick_ls;
        if_req_ready = pick_if;
        ls_req_ready = pick_ls;
        accept       = pick_if | pick_ls;
        if (accept) begin
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (count == 4'd0) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count        <= 4'd0;
      last_grant   <= GRANT_LS;
      owner        <= GRANT_IF;
      write_lat    <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      ls_rsp_data  <= '0;
      busy         <= 1'b0;
    end else begin
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      busy         <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            owner      <= pick_ls;
            last_grant <= pick_ls;
            write_lat  <= pick_ls & ls_write;
            mem_en     <= 1'b1;
            mem_we     <= pick_ls & ls_write;
            mem_addr   <= pick_ls ? ls_addr : if_addr;
            mem_wdata  <= pick_ls ? ls_wdata : '0;
          end
        end
        ISSUE: count <= WAIT_LOAD;
        // Read data is valid in the last WAIT cycle; capture only into the owner's port.
        WAIT: begin
          if (count == 4'd0) begin
            if (owner == GRANT_LS) begin
              ls_rsp_data  <= write_lat ? '0 : mem_rdata;
              ls_rsp_valid <= 1'b1;
            end else begin
              if_rsp_data  <= mem_rdata;
              if_rsp_valid <= 1'b1;
            end
          end else begin
            count <= count - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance A (round-robin, latency 1) and
// instance B (fixed priority, latency 3).
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;

  logic        if_valid_a, if_ready_a, if_rsp_valid_a, ls_valid_a, ls_ready_a, ls_write_a;
  logic        ls_rsp_valid_a, mem_en_a, mem_we_a, busy_a;
  logic [31:0] if_addr_a, if_rsp_data_a, ls_addr_a, ls_wdata_a, ls_rsp_data_a;
  logic [31:0] mem_addr_a, mem_wdata_a, rdata_a;

  logic        if_valid_b, if_ready_b, if_rsp_valid_b, ls_valid_b, ls_ready_b, ls_write_b;
  logic        ls_rsp_valid_b, mem_en_b, mem_we_b, busy_b;
  logic [31:0] if_addr_b, if_rsp_data_b, ls_addr_b, ls_wdata_b, ls_rsp_data_b;
  logic [31:0] mem_addr_b, mem_wdata_b, rdata_b;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .RR_EN(1)) dut_a (
    .clk(clk), .rst(rst),
    .if_req_valid(if_valid_a), .if_req_ready(if_ready_a), .if_addr(if_addr_a),
    .if_rsp_valid(if_rsp_valid_a), .if_rsp_data(if_rsp_data_a),
    .ls_req_valid(ls_valid_a), .ls_req_ready(ls_ready_a), .ls_addr(ls_addr_a),
    .ls_write(ls_write_a), .ls_wdata(ls_wdata_a),
    .ls_rsp_valid(ls_rsp_valid_a), .ls_rsp_data(ls_rsp_data_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(rdata_a), .busy(busy_a)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .RR_EN(0)) dut_b (
    .clk(clk), .rst(rst),
    .if_req_valid(if_valid_b), .if_req_ready(if_ready_b), .if_addr(if_addr_b),
    .if_rsp_valid(if_rsp_valid_b), .if_rsp_data(if_rsp_data_b),
    .ls_req_valid(ls_valid_b), .ls_req_ready(ls_ready_b), .ls_addr(ls_addr_b),
    .ls_write(ls_write_b), .ls_wdata(ls_wdata_b),
    .ls_rsp_valid(ls_rsp_valid_b), .ls_rsp_data(ls_rsp_data_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(rdata_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_idle(input bit which);
    int w;
    w = 0;
    while (((which ? busy_b : busy_a) !== 1'b0) && w < 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    checks++;
    if ((which ? busy_b : busy_a) !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle(%0d): busy still %b after 50 cycles, expected 0", which,
               which ? busy_b : busy_a);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy_a, mem_en_a, mem_we_a, if_rsp_valid_a, ls_rsp_valid_a} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl_a: got %b expected 00000",
               {busy_a, mem_en_a, mem_we_a, if_rsp_valid_a, ls_rsp_valid_a});
    end
    checks++;
    if ({mem_addr_a, mem_wdata_a, if_rsp_data_a, ls_rsp_data_a} !== 128'd0) begin
      errors++;
      $display("FAIL reset_data_a: got %h expected 0",
               {mem_addr_a, mem_wdata_a, if_rsp_data_a, ls_rsp_data_a});
    end
    checks++;
    if ({busy_b, mem_en_b, if_rsp_valid_b, ls_rsp_valid_b} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl_b: got %b expected 0000",
               {busy_b, mem_en_b, if_rsp_valid_b, ls_rsp_valid_b});
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({if_ready_a, ls_ready_a} !== 2'b00) begin
      errors++;
      $display("FAIL idle_no_req_ready: got %b expected 00", {if_ready_a, ls_ready_a});
    end
    // First tie after reset goes to IF; withdraw before the edge so nothing is accepted.
    if_valid_a = 1'b1;
    ls_valid_a = 1'b1;
    #1;
    checks++;
    if ({if_ready_a, ls_ready_a} !== 2'b10) begin
      errors++;
      $display("FAIL first_tie_rr: got %b expected 10", {if_ready_a, ls_ready_a});
    end
    if_valid_a = 1'b0;
    ls_valid_a = 1'b0;
  endtask

  task automatic test_if_read;
    @(negedge clk);
    if_valid_a = 1'b1;
    if_addr_a  = 32'h10;
    rdata_a    = 32'hDEADBEEF;
    #1;
    checks++;
    if ({if_ready_a, ls_ready_a} !== 2'b10) begin
      errors++;
      $display("FAIL if_read_ready: got %b expected 10", {if_ready_a, ls_ready_a});
    end
    @(negedge clk);
    if_valid_a = 1'b0;
    checks++;
    if ({mem_en_a, mem_we_a, mem_addr_a} !== {1'b1, 1'b0, 32'h10}) begin
      errors++;
      $display("FAIL if_read_issue: got en=%b we=%b addr=%h expected en=1 we=0 addr=00000010",
               mem_en_a, mem_we_a, mem_addr_a);
    end
    @(negedge clk);
    checks++;
    if ({mem_en_a, if_rsp_valid_a, mem_addr_a} !== {1'b0, 1'b0, 32'h10}) begin
      errors++;
      $display("FAIL if_read_wait: got en=%b rsp=%b addr=%h expected en=0 rsp=0 addr=00000010",
               mem_en_a, if_rsp_valid_a, mem_addr_a);
    end
    @(negedge clk);
    checks++;
    if ({if_rsp_valid_a, ls_rsp_valid_a, if_rsp_data_a} !== {2'b10, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL if_read_rsp: got if=%b ls=%b data=%h expected if=1 ls=0 data=deadbeef",
               if_rsp_valid_a, ls_rsp_valid_a, if_rsp_data_a);
    end
    @(negedge clk);
    checks++;
    if ({if_rsp_valid_a, busy_a, if_rsp_data_a} !== {2'b00, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL if_read_after: got rsp=%b busy=%b data=%h expected rsp=0 busy=0 data=deadbeef",
               if_rsp_valid_a, busy_a, if_rsp_data_a);
    end
  endtask

  task automatic test_ls_store;
    ls_valid_a = 1'b1;
    ls_write_a = 1'b1;
    ls_addr_a  = 32'h20;
    ls_wdata_a = 32'h12345678;
    rdata_a    = 32'hFFFFFFFF;
    #1;
    checks++;
    if ({if_ready_a, ls_ready_a} !== 2'b01) begin
      errors++;
      $display("FAIL store_ready: got %b expected 01", {if_ready_a, ls_ready_a});
    end
    @(negedge clk);
    ls_valid_a = 1'b0;
    checks++;
    if ({mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a} !== {2'b11, 32'h20, 32'h12345678}) begin
      errors++;
      $display("FAIL store_issue: got en=%b we=%b addr=%h wdata=%h expected 1 1 00000020 12345678",
               mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a);
    end
    @(negedge clk);
    checks++;
    if ({mem_en_a, mem_we_a} !== 2'b00) begin
      errors++;
      $display("FAIL store_we_one_cycle: got %b expected 00", {mem_en_a, mem_we_a});
    end
    @(negedge clk);
    checks++;
    if ({ls_rsp_valid_a, if_rsp_valid_a, ls_rsp_data_a} !== {2'b10, 32'h0}) begin
      errors++;
      $display("FAIL store_rsp: got ls=%b if=%b data=%h expected ls=1 if=0 data=00000000",
               ls_rsp_valid_a, if_rsp_valid_a, ls_rsp_data_a);
    end
    checks++;
    if (if_rsp_data_a !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL non_owner_data_kept: got %h expected deadbeef", if_rsp_data_a);
    end
    ls_write_a = 1'b0;
    wait_idle(1'b0);
  endtask

  task automatic test_round_robin;
    int w;
    logic granted [4];
    int   t [4];
    @(negedge clk);
    if_valid_a = 1'b1;
    ls_valid_a = 1'b1;
    if_addr_a  = 32'h100;
    ls_addr_a  = 32'h200;
    ls_write_a = 1'b0;
    rdata_a    = 32'h11112222;
    #1;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (!(if_ready_a || ls_ready_a) && w < 10) begin
        @(negedge clk);
        #1;
        w++;
      end
      granted[k] = ls_ready_a;
      t[k]       = cyc;
      checks++;
      if (!(if_ready_a || ls_ready_a) || granted[k] !== k[0]) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got ls_ready=%b if_ready=%b expected ls_ready=%0d",
                 k, ls_ready_a, if_ready_a, k % 2);
      end
      if (k > 0) begin
        checks++;
        if (t[k] - t[k-1] !== 4) begin
          errors++;
          $display("FAIL rr_spacing[%0d]: got %0d cycles expected 4", k, t[k] - t[k-1]);
        end
      end
      @(negedge clk);
      #1;
    end
    if_valid_a = 1'b0;
    ls_valid_a = 1'b0;
    wait_idle(1'b0);
  endtask

  task automatic test_fixed_priority;
    int ls_acc;
    int first_t;
    int last_t;
    logic if_seen;
    ls_acc  = 0;
    first_t = 0;
    last_t  = 0;
    if_seen = 1'b0;
    @(negedge clk);
    if_valid_b = 1'b1;
    ls_valid_b = 1'b1;
    if_addr_b  = 32'h300;
    ls_addr_b  = 32'h400;
    ls_write_b = 1'b0;
    rdata_b    = 32'h5555AAAA;
    #1;
    for (int i = 0; i < 18; i++) begin
      if (ls_ready_b) begin
        if (ls_acc == 0) first_t = cyc;
        last_t = cyc;
        ls_acc++;
      end
      if_seen = if_seen | if_ready_b;
      @(negedge clk);
      #1;
    end
    checks++;
    if (ls_acc !== 3 || if_seen !== 1'b0) begin
      errors++;
      $display("FAIL fixed_prio: got ls_accepts=%0d if_ready_seen=%b expected 3 and 0",
               ls_acc, if_seen);
    end
    checks++;
    if (last_t - first_t !== 12) begin
      errors++;
      $display("FAIL fixed_spacing: got %0d cycles expected 12", last_t - first_t);
    end
    ls_valid_b = 1'b0;
    #1;
    checks++;
    if ({if_ready_b, ls_ready_b} !== 2'b10) begin
      errors++;
      $display("FAIL fixed_if_after_ls: got %b expected 10", {if_ready_b, ls_ready_b});
    end
    @(negedge clk);
    if_valid_b = 1'b0;
    wait_idle(1'b1);
  endtask

  task automatic test_latency3;
    @(negedge clk);
    if_valid_b = 1'b1;
    if_addr_b  = 32'h40;
    rdata_b    = 32'hCAFEF00D;
    #1;
    checks++;
    if (if_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL lat3_accept: got %b expected 1", if_ready_b);
    end
    for (int off = 1; off <= 5; off++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({mem_en_b, if_ready_b, ls_ready_b, if_rsp_valid_b} !==
          {(off == 1), 2'b00, (off == 5)}) begin
        errors++;
        $display("FAIL lat3_t+%0d: got en=%b rdy=%b%b rsp=%b expected en=%0d rdy=00 rsp=%0d",
                 off, mem_en_b, if_ready_b, ls_ready_b, if_rsp_valid_b, off == 1, off == 5);
      end
    end
    checks++;
    if (if_rsp_data_b !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL lat3_data: got %h expected cafef00d", if_rsp_data_b);
    end
    @(negedge clk);
    if_valid_b = 1'b0;
    checks++;
    if ({if_rsp_valid_b, busy_b} !== 2'b00) begin
      errors++;
      $display("FAIL lat3_done: got rsp=%b busy=%b expected 0 0", if_rsp_valid_b, busy_b);
    end
  endtask

  task automatic test_reset_mid;
    logic pulse;
    pulse = 1'b0;
    @(negedge clk);
    ls_valid_a = 1'b1;
    ls_write_a = 1'b0;
    ls_addr_a  = 32'h30;
    rdata_a    = 32'h0BADF00D;
    #1;
    checks++;
    if (ls_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_accept: got %b expected 1", ls_ready_a);
    end
    @(negedge clk);
    ls_valid_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if ({busy_a, mem_en_a, mem_we_a, ls_rsp_valid_a, ls_rsp_data_a} !== 36'd0) begin
      errors++;
      $display("FAIL rstmid_state: got busy=%b en=%b we=%b rsp=%b data=%h expected all 0",
               busy_a, mem_en_a, mem_we_a, ls_rsp_valid_a, ls_rsp_data_a);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pulse = pulse | ls_rsp_valid_a | if_rsp_valid_a;
    end
    checks++;
    if (pulse !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_rsp: got pulse=%b expected 0", pulse);
    end
    if_valid_a = 1'b1;
    ls_valid_a = 1'b1;
    if_addr_a  = 32'h50;
    rdata_a    = 32'h600DCAFE;
    #1;
    checks++;
    if ({if_ready_a, ls_ready_a} !== 2'b10) begin
      errors++;
      $display("FAIL rstmid_tie: got %b expected 10", {if_ready_a, ls_ready_a});
    end
    @(negedge clk);
    if_valid_a = 1'b0;
    ls_valid_a = 1'b0;
    checks++;
    if ({mem_en_a, mem_addr_a} !== {1'b1, 32'h50}) begin
      errors++;
      $display("FAIL rstmid_issue: got en=%b addr=%h expected 1 00000050", mem_en_a, mem_addr_a);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({if_rsp_valid_a, ls_rsp_valid_a, if_rsp_data_a} !== {2'b10, 32'h600DCAFE}) begin
      errors++;
      $display("FAIL rstmid_rsp: got if=%b ls=%b data=%h expected 1 0 600dcafe",
               if_rsp_valid_a, ls_rsp_valid_a, if_rsp_data_a);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    if_valid_a = 1'b0; ls_valid_a = 1'b0; ls_write_a = 1'b0;
    if_addr_a  = '0;   ls_addr_a  = '0;   ls_wdata_a = '0;   rdata_a = '0;
    if_valid_b = 1'b0; ls_valid_b = 1'b0; ls_write_b = 1'b0;
    if_addr_b  = '0;   ls_addr_b  = '0;   ls_wdata_b = '0;   rdata_b = '0;
    test_reset();
    test_if_read();
    test_ls_store();
    test_round_robin();
    test_fixed_priority();
    test_latency3();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
